// File: rtl/variable_width_queue_input_arbiter_if.sv
// Bus bundle between the per-port input stages, the input arbiter and the
// variable-width queue write side.
//
// Handshake: a beat moves on port p at a rising clk edge where s_tvalid[p]
// and s_tready[p] are both high. Once a source raises s_tvalid it holds the
// beat (tdata/tkeep/tuser/tlast) stable until it is accepted. The queue
// takes a beat at every rising edge where q_write is high; q_write is only
// raised while q_can_write is high.
//
// Modports: master = arbiter, slave = environment (input stages + queue).
interface variable_width_queue_input_arbiter_if #(
    parameter int NUM_PORTS   = 4,
    parameter int TDATA_WIDTH = 256,
    parameter int TUSER_WIDTH = 128
);
    localparam int TKEEP_WIDTH = TDATA_WIDTH / 8;

    logic [NUM_PORTS*TDATA_WIDTH-1:0] s_tdata;
    logic [NUM_PORTS*TKEEP_WIDTH-1:0] s_tkeep;
    logic [NUM_PORTS*TUSER_WIDTH-1:0] s_tuser;
    logic [NUM_PORTS-1:0]             s_tlast;
    logic [NUM_PORTS-1:0]             s_tvalid;
    logic [NUM_PORTS-1:0]             s_tready;

    logic [TDATA_WIDTH-1:0]           q_tdata;
    logic [TKEEP_WIDTH-1:0]           q_tkeep;
    logic [TUSER_WIDTH-1:0]           q_tuser;
    logic                             q_tlast;
    logic                             q_write;
    logic                             q_can_write;

    modport master (
        input  s_tdata, s_tkeep, s_tuser, s_tlast, s_tvalid, q_can_write,
        output s_tready, q_tdata, q_tkeep, q_tuser, q_tlast, q_write
    );

    modport slave (
        output s_tdata, s_tkeep, s_tuser, s_tlast, s_tvalid, q_can_write,
        input  s_tready, q_tdata, q_tkeep, q_tuser, q_tlast, q_write
    );
endinterface

// File: rtl/variable_width_queue_input_arbiter.sv
// Packet-atomic round-robin arbiter sharing the write side of one
// variable-width queue among NUM_PORTS stream requesters. A grant is held
// from the first beat of a packet through its tlast beat, so packets from
// different ports never interleave. Each packet costs one idle arbitration
// cycle; beats then pass combinationally with no added latency.
//
// Optional feature macro: ARB_PKT_COUNT_EN adds pkt_count, one 32-bit
// wrapping packet counter per port, bumped on that port's tlast transfer.
module variable_width_queue_input_arbiter #(
    parameter int NUM_PORTS   = 4,
    parameter int TDATA_WIDTH = 256,
    parameter int TUSER_WIDTH = 128,
    localparam int TKEEP_WIDTH = TDATA_WIDTH / 8,
    localparam int PORT_BITS   = $clog2(NUM_PORTS)
) (
    input  logic                   clk,
    input  logic                   reset,
    variable_width_queue_input_arbiter_if.master bus,
    output logic                   grant_valid,
    output logic [PORT_BITS-1:0]   grant_id,
    output logic                   state_dbg
`ifdef ARB_PKT_COUNT_EN
    ,
    output logic [NUM_PORTS*32-1:0] pkt_count
`endif
);

    typedef enum logic {
        IDLE    = 1'b0,
        GRANTED = 1'b1
    } state_e;

    state_e                 state_q;
    logic [PORT_BITS-1:0]   last_grant;
    logic [PORT_BITS-1:0]   winner;
    logic [NUM_PORTS-1:0]   req_rot;
    int                     shamt;
    int                     sum;
    logic                   found;

    logic [TDATA_WIDTH-1:0] sel_tdata;
    logic [TKEEP_WIDTH-1:0] sel_tkeep;
    logic [TUSER_WIDTH-1:0] sel_tuser;
    logic                   sel_tlast;
    logic                   sel_valid;
    logic [NUM_PORTS-1:0]   tready;
    logic                   q_write_w;

    assign state_dbg = state_q;

    // Round-robin pick: rotate requests so last_grant+1 lands on bit 0, then
    // take the lowest set bit and map it back to a port index.
    always_comb begin
        shamt   = int'(last_grant) + 1;
        req_rot = NUM_PORTS'({bus.s_tvalid, bus.s_tvalid} >> shamt);
        winner  = '0;
        found   = 1'b0;
        sum     = 0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (!found && req_rot[k]) begin
                found = 1'b1;
                sum   = int'(last_grant) + 1 + k;
                if (sum >= NUM_PORTS) begin
                    sum = sum - NUM_PORTS;
                end
                winner = PORT_BITS'(sum);
            end
        end
    end

    // Select the granted port's beat; everything is zero when no grant is held.
    always_comb begin
        sel_tdata = '0;
        sel_tkeep = '0;
        sel_tuser = '0;
        sel_tlast = 1'b0;
        sel_valid = 1'b0;
        tready    = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (grant_valid && (grant_id == PORT_BITS'(p))) begin
                sel_tdata = bus.s_tdata[p*TDATA_WIDTH +: TDATA_WIDTH];
                sel_tkeep = bus.s_tkeep[p*TKEEP_WIDTH +: TKEEP_WIDTH];
                sel_tuser = bus.s_tuser[p*TUSER_WIDTH +: TUSER_WIDTH];
                sel_tlast = bus.s_tlast[p];
                sel_valid = bus.s_tvalid[p];
                tready[p] = bus.q_can_write;
            end
        end
    end

    assign q_write_w    = sel_valid & bus.q_can_write;
    assign bus.q_tdata  = sel_tdata;
    assign bus.q_tkeep  = sel_tkeep;
    assign bus.q_tuser  = sel_tuser;
    assign bus.q_tlast  = sel_tlast;
    assign bus.q_write  = q_write_w;
    assign bus.s_tready = tready;

    // Grant FSM: one idle cycle to arbitrate, then hold until the tlast beat
    // is written to the queue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            last_grant  <= PORT_BITS'(NUM_PORTS - 1);
        end else begin
            case (state_q)
                IDLE: begin
                    if (|bus.s_tvalid) begin
                        grant_id    <= winner;
                        grant_valid <= 1'b1;
                        state_q     <= GRANTED;
                    end
                end
                GRANTED: begin
                    if (q_write_w && sel_tlast) begin
                        last_grant  <= grant_id;
                        grant_valid <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    grant_valid <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

`ifdef ARB_PKT_COUNT_EN
    logic [NUM_PORTS*32-1:0] pkt_count_nxt;

    // Bump a port's counter on its accepted tlast beat; wraps naturally.
    always_comb begin
        pkt_count_nxt = pkt_count;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (tready[p] && bus.s_tvalid[p] && bus.s_tlast[p]) begin
                pkt_count_nxt[p*32 +: 32] = pkt_count[p*32 +: 32] + 32'd1;
            end
        end
    end

    // Packet counter register bank.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pkt_count <= '0;
        end else begin
            pkt_count <= pkt_count_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_variable_width_queue_input_arbiter.sv
// Bench for variable_width_queue_input_arbiter: per-port AXI-style sources,
// a queue-side monitor with an expected-beat scoreboard, and one task per
// scenario. Define ARB_PKT_COUNT_EN to also exercise the packet counters.
module tb_variable_width_queue_input_arbiter;
    localparam int NP = 4;
    localparam int DW = 256;
    localparam int UW = 128;
    localparam int KW = DW / 8;
    localparam int PB = 2;
    localparam int BW = DW + KW + UW + 1;
    localparam int EW = BW + PB;
    localparam int DEPTH = 64;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    variable_width_queue_input_arbiter_if #(.NUM_PORTS(NP), .TDATA_WIDTH(DW), .TUSER_WIDTH(UW)) bus ();

    logic          grant_valid;
    logic [PB-1:0] grant_id;
    logic          state_dbg;
`ifdef ARB_PKT_COUNT_EN
    logic [NP*32-1:0] pkt_count;
`endif

    variable_width_queue_input_arbiter #(
        .NUM_PORTS(NP), .TDATA_WIDTH(DW), .TUSER_WIDTH(UW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .grant_valid(grant_valid),
        .grant_id(grant_id),
        .state_dbg(state_dbg)
`ifdef ARB_PKT_COUNT_EN
        ,
        .pkt_count(pkt_count)
`endif
    );

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q[$];
    int            wr_cyc[$];
    int            n_vec = 0;
    int            n_err = 0;

    logic [BW-1:0] mem [NP][DEPTH];
    int            head [NP];
    int            tail [NP];
    logic [NP-1:0] acc = '0;
    logic          prev_last = 1'b0;

    // ---------------- source driver ----------------
    // Presents each port's next pending beat; advances only after acceptance.
    always @(posedge clk) begin
        #1;
        for (int p = 0; p < NP; p++) begin
            if (acc[p] && head[p] < tail[p]) head[p]++;
            if (head[p] < tail[p]) begin
                bus.s_tvalid[p]            = 1'b1;
                bus.s_tdata[p*DW +: DW]    = mem[p][head[p]][BW-1 -: DW];
                bus.s_tkeep[p*KW +: KW]    = mem[p][head[p]][UW+1 +: KW];
                bus.s_tuser[p*UW +: UW]    = mem[p][head[p]][1 +: UW];
                bus.s_tlast[p]             = mem[p][head[p]][0];
            end else begin
                bus.s_tvalid[p] = 1'b0;
            end
        end
    end

    // ---------------- queue-side monitor ----------------
    always @(negedge clk) begin
        logic [EW-1:0] got;
        logic [EW-1:0] exp;
        acc = bus.s_tvalid & bus.s_tready;
        if (prev_last) begin
            n_vec++;
            if (grant_valid !== 1'b0) begin
                n_err++;
                $display("FAIL post_tlast_release: grant_valid=%b required 0", grant_valid);
            end
        end
        prev_last = (bus.q_write === 1'b1) && (bus.q_tlast === 1'b1);
        if (bus.q_write === 1'b1) begin
            got = {grant_id, bus.q_tdata, bus.q_tkeep, bus.q_tuser, bus.q_tlast};
            wr_cyc.push_back(cyc);
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL beat_unexpected: got %h required none", got);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    n_err++;
                    $display("FAIL beat: got %h required %h", got, exp);
                end
            end
        end else if (bus.q_write !== 1'b0) begin
            n_vec++;
            n_err++;
            $display("FAIL q_write_known: got %b required 0/1", bus.q_write);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_pkt(input int p, input int nb, input int nexp);
        logic [BW-1:0] b;
        logic [DW-1:0] d;
        logic [KW-1:0] kp;
        logic [UW-1:0] u;
        if (head[p] == tail[p]) begin
            head[p] = 0;
            tail[p] = 0;
        end
        for (int k = 0; k < nb; k++) begin
            for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
            for (int i = 0; i < UW / 32; i++) u[i*32 +: 32] = $urandom;
            kp = (k == nb - 1) ? KW'($urandom_range(1, 32'h7fff_ffff)) : {KW{1'b1}};
            b = {d, kp, u, (k == nb - 1)};
            mem[p][tail[p]] = b;
            tail[p]++;
            if (k < nexp) exp_q.push_back({PB'(p), b});
        end
    endtask

    task automatic flush_sources();
        for (int p = 0; p < NP; p++) begin
            head[p] = 0;
            tail[p] = 0;
        end
        bus.s_tvalid = '0;
        acc = '0;
    endtask

    function automatic bit sources_busy();
        for (int p = 0; p < NP; p++) if (head[p] < tail[p]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        flush_sources();
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #2;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || sources_busy() || grant_valid !== 1'b0) && n < budget) begin
            @(posedge clk);
            #2;
            n++;
        end
        n_vec++;
        if (n >= budget) begin
            n_err++;
            $display("FAIL drain_timeout: %0d beats still expected, required 0", exp_q.size());
            exp_q.delete();
            flush_sources();
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #3;
        n_vec++;
        if (grant_valid !== 1'b0 || grant_id !== '0 || state_dbg !== 1'b0) begin
            n_err++;
            $display("FAIL reset_grant: valid=%b id=%0d state=%b required 0/0/0", grant_valid, grant_id, state_dbg);
        end
        n_vec++;
        if (bus.q_write !== 1'b0 || bus.s_tready !== '0 || bus.q_tlast !== 1'b0) begin
            n_err++;
            $display("FAIL reset_handshake: q_write=%b s_tready=%b q_tlast=%b required 0", bus.q_write, bus.s_tready, bus.q_tlast);
        end
        n_vec++;
        if (bus.q_tdata !== '0 || bus.q_tkeep !== '0 || bus.q_tuser !== '0) begin
            n_err++;
            $display("FAIL reset_data: q_tdata/q_tkeep/q_tuser not all zero, required 0");
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #2;
    endtask

    task automatic test_single_port();
        send_pkt(2, 3, 3);
        @(posedge clk); #2;
        n_vec++;
        if (bus.s_tvalid[2] !== 1'b1 || grant_valid !== 1'b0 || bus.q_write !== 1'b0) begin
            n_err++;
            $display("FAIL single_arb_cycle: tvalid=%b grant_valid=%b q_write=%b required 1/0/0", bus.s_tvalid[2], grant_valid, bus.q_write);
        end
        @(posedge clk); #2;
        n_vec++;
        if (grant_valid !== 1'b1 || grant_id !== 2'd2 || state_dbg !== 1'b1) begin
            n_err++;
            $display("FAIL single_grant: valid=%b id=%0d state=%b required 1/2/1", grant_valid, grant_id, state_dbg);
        end
        for (int k = 0; k < 3; k++) begin
            if (k > 0) begin @(posedge clk); #2; end
            n_vec++;
            if (bus.q_write !== 1'b1 || bus.q_tlast !== (k == 2) || bus.s_tready !== 4'b0100) begin
                n_err++;
                $display("FAIL single_beat%0d: q_write=%b q_tlast=%b s_tready=%b required 1/%0d/0100", k, bus.q_write, bus.q_tlast, bus.s_tready, (k == 2));
            end
        end
        @(posedge clk); #2;
        n_vec++;
        if (grant_valid !== 1'b0 || bus.q_write !== 1'b0) begin
            n_err++;
            $display("FAIL single_release: grant_valid=%b q_write=%b required 0/0", grant_valid, bus.q_write);
        end
        wait_drain(50);
    endtask

    task automatic test_fairness();
        apply_reset();
        wr_cyc.delete();
        send_pkt(0, 1, 1);
        send_pkt(1, 1, 1);
        send_pkt(2, 1, 1);
        send_pkt(3, 1, 1);
        send_pkt(0, 1, 1);
        send_pkt(1, 1, 1);
        wait_drain(100);
        n_vec++;
        if (wr_cyc.size() != 6) begin
            n_err++;
            $display("FAIL fair_count: writes=%0d required 6", wr_cyc.size());
        end else begin
            for (int k = 1; k < 6; k++) begin
                n_vec++;
                if (wr_cyc[k] - wr_cyc[k-1] != 2) begin
                    n_err++;
                    $display("FAIL fair_spacing%0d: gap=%0d required 2", k, wr_cyc[k] - wr_cyc[k-1]);
                end
            end
        end
    endtask

    task automatic test_no_preempt();
        send_pkt(1, 4, 4);
        @(posedge clk); #2;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #2;
            if (k == 1) send_pkt(0, 1, 1);
            n_vec++;
            if (grant_valid !== 1'b1 || grant_id !== 2'd1 || bus.q_write !== 1'b1 || bus.s_tready[0] !== 1'b0) begin
                n_err++;
                $display("FAIL hold_beat%0d: valid=%b id=%0d q_write=%b tready0=%b required 1/1/1/0", k, grant_valid, grant_id, bus.q_write, bus.s_tready[0]);
            end
        end
        @(posedge clk); #2;
        n_vec++;
        if (grant_valid !== 1'b0 || bus.s_tvalid[0] !== 1'b1) begin
            n_err++;
            $display("FAIL hold_idle: grant_valid=%b tvalid0=%b required 0/1", grant_valid, bus.s_tvalid[0]);
        end
        @(posedge clk); #2;
        n_vec++;
        if (grant_valid !== 1'b1 || grant_id !== 2'd0) begin
            n_err++;
            $display("FAIL hold_next_grant: valid=%b id=%0d required 1/0", grant_valid, grant_id);
        end
        wait_drain(50);
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] held;
        send_pkt(3, 2, 2);
        @(posedge clk); #2;
        @(posedge clk); #2;
        n_vec++;
        if (bus.q_write !== 1'b1 || grant_id !== 2'd3) begin
            n_err++;
            $display("FAIL bp_first: q_write=%b id=%0d required 1/3", bus.q_write, grant_id);
        end
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #2;
            bus.q_can_write = 1'b0;
            #1;
            held = exp_q[0][BW-1 -: DW];
            n_vec++;
            if (bus.q_write !== 1'b0 || bus.s_tready !== '0 || bus.q_tdata !== held) begin
                n_err++;
                $display("FAIL bp_stall%0d: q_write=%b s_tready=%b data_held=%b required 0/0000/1", k, bus.q_write, bus.s_tready, bus.q_tdata === held);
            end
        end
        @(posedge clk); #2;
        bus.q_can_write = 1'b1;
        #1;
        n_vec++;
        if (bus.q_write !== 1'b1 || bus.q_tlast !== 1'b1) begin
            n_err++;
            $display("FAIL bp_resume: q_write=%b q_tlast=%b required 1/1", bus.q_write, bus.q_tlast);
        end
        wait_drain(50);
    endtask

    task automatic test_reset_mid();
        send_pkt(0, 1, 1);
        wait_drain(50);
        send_pkt(2, 5, 1);
        @(posedge clk); #2;
        @(posedge clk); #2;
        @(posedge clk); #2;
        n_vec++;
        if (bus.q_write !== 1'b1 || grant_id !== 2'd2) begin
            n_err++;
            $display("FAIL rstmid_pre: q_write=%b id=%0d required 1/2", bus.q_write, grant_id);
        end
        reset = 1'b1;
        flush_sources();
        #1;
        n_vec++;
        if (grant_valid !== 1'b0 || grant_id !== '0 || bus.q_write !== 1'b0 || bus.s_tready !== '0) begin
            n_err++;
            $display("FAIL rstmid_async: valid=%b id=%0d q_write=%b s_tready=%b required 0/0/0/0", grant_valid, grant_id, bus.q_write, bus.s_tready);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #2;
        send_pkt(0, 1, 1);
        send_pkt(1, 1, 1);
        @(posedge clk); #2;
        @(posedge clk); #2;
        n_vec++;
        if (grant_valid !== 1'b1 || grant_id !== 2'd0) begin
            n_err++;
            $display("FAIL rstmid_first: valid=%b id=%0d required 1/0", grant_valid, grant_id);
        end
        wait_drain(50);
    endtask

`ifdef ARB_PKT_COUNT_EN
    task automatic test_pkt_count();
        logic [NP*32-1:0] pre;
        apply_reset();
        for (int k = 0; k < 5; k++) send_pkt(3, 1, 1);
        wait_drain(100);
        n_vec++;
        if (pkt_count !== {32'd5, 32'd0, 32'd0, 32'd0}) begin
            n_err++;
            $display("FAIL pkt_count5: got %h required %h", pkt_count, {32'd5, 32'd0, 32'd0, 32'd0});
        end
        pre = pkt_count;
        pre[3*32 +: 32] = 32'hFFFF_FFFF;
        force dut.pkt_count = pre;
        #1;
        release dut.pkt_count;
        send_pkt(3, 1, 1);
        wait_drain(50);
        n_vec++;
        if (pkt_count[3*32 +: 32] !== 32'd0) begin
            n_err++;
            $display("FAIL pkt_count_wrap: got %h required 0", pkt_count[3*32 +: 32]);
        end
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        reset           = 1'b1;
        bus.q_can_write = 1'b1;
        bus.s_tvalid    = '0;
        bus.s_tdata     = '0;
        bus.s_tkeep     = '0;
        bus.s_tuser     = '0;
        bus.s_tlast     = '0;
        for (int p = 0; p < NP; p++) begin
            head[p] = 0;
            tail[p] = 0;
        end
        test_reset();
        test_single_port();
        test_fairness();
        test_no_preempt();
        test_backpressure();
        test_reset_mid();
`ifdef ARB_PKT_COUNT_EN
        test_pkt_count();
`endif
        repeat (3) @(posedge clk);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL leftover: %0d beats never written, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
